bank_burst_sequencer: RTL

BANK_BURST_SEQUENCER -- requirements
Module: bank_burst_sequencer

---
 rtl/bank_burst_sequencer.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bank_burst_sequencer.sv
// ---------------------------------------------------------------------------
// bank_burst_sequencer
//
// Purpose:
//   Accepts one read or write burst command at a time and plays it out as
//   BL consecutive beats onto the selected bank [bg][ba] of a multi-bank
//   device. Each beat drives the latched row, a column that wraps
//   sequentially inside the BL-aligned block, and the write strobe and data
//   for write bursts. Every other bank is held at zero. A new command can be
//   accepted on the last beat, so bursts can run back to back with no gap.
//
// Optional feature:
//   BURST_CHOP_EN - when defined, adds input cmd_bc4. A command accepted
//   with cmd_bc4=1 runs a 4-beat burst whose column wraps inside a 4-aligned
//   block. When undefined, every burst is BL beats and cmd_bc4 is absent.
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   cmd_valid    command offered
//   cmd_ready    command accepted when high together with cmd_valid
//   cmd_wr       1 = write burst, 0 = read burst
//   cmd_bg       target bank group
//   cmd_ba       target bank within the group
//   cmd_row      row address
//   cmd_col      start column
//   cmd_bc4      (BURST_CHOP_EN only) 4-beat burst chop
//   cmd_wdata    write burst, beat k at [k*DEVICE_WIDTH +: DEVICE_WIDTH]
//   rd_o_wr      per-bank write strobe
//   dqin         per-bank write data
//   row          per-bank row
//   column       per-bank column
//   beat_valid   a burst beat is driven this cycle
//   beat_idx     index of the current beat
//   burst_done   one-cycle pulse on the last beat
// ---------------------------------------------------------------------------
module bank_burst_sequencer #(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int ADDRWIDTH    = 17,
  parameter int COLWIDTH     = 10,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_wr,
  input  logic [BGWIDTH-1:0]         cmd_bg,
  input  logic [BAWIDTH-1:0]         cmd_ba,
  input  logic [ADDRWIDTH-1:0]       cmd_row,
  input  logic [COLWIDTH-1:0]        cmd_col,
`ifdef BURST_CHOP_EN
  input  logic                       cmd_bc4,
`endif
  input  logic [DEVICE_WIDTH*BL-1:0] cmd_wdata,
  output logic                       rd_o_wr [(1<<BGWIDTH)][(1<<BAWIDTH)],
  output logic [DEVICE_WIDTH-1:0]    dqin    [(1<<BGWIDTH)][(1<<BAWIDTH)],
  output logic [ADDRWIDTH-1:0]       row     [(1<<BGWIDTH)][(1<<BAWIDTH)],
  output logic [COLWIDTH-1:0]        column  [(1<<BGWIDTH)][(1<<BAWIDTH)],
  output logic                       beat_valid,
  output logic [$clog2(BL)-1:0]      beat_idx,
  output logic                       burst_done
);

  localparam int BANKGROUPS    = 2**BGWIDTH;
  localparam int BANKSPERGROUP = 2**BAWIDTH;
  localparam int BLW           = $clog2(BL);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Control state and the command fields captured on accept.
  state_t                    state_q, state_d;
  logic [BLW-1:0]            cnt_q, cnt_d;
  logic                      wr_q, wr_d;
  logic [BGWIDTH-1:0]        bg_q, bg_d;
  logic [BAWIDTH-1:0]        ba_q, ba_d;
  logic [ADDRWIDTH-1:0]      row_lat_q, row_lat_d;
  logic [COLWIDTH-1:0]       col_lat_q, col_lat_d;
  logic [DEVICE_WIDTH*BL-1:0] wdata_q, wdata_d;
  logic                      bc4_q, bc4_d;

  // Registered copies of every output so that beat 0 appears exactly one
  // cycle after the accept edge.
  logic                      bank_wr_q  [BANKGROUPS][BANKSPERGROUP];
  logic                      bank_wr_d  [BANKGROUPS][BANKSPERGROUP];
  logic [DEVICE_WIDTH-1:0]   bank_dq_q  [BANKGROUPS][BANKSPERGROUP];
  logic [DEVICE_WIDTH-1:0]   bank_dq_d  [BANKGROUPS][BANKSPERGROUP];
  logic [ADDRWIDTH-1:0]      bank_row_q [BANKGROUPS][BANKSPERGROUP];
  logic [ADDRWIDTH-1:0]      bank_row_d [BANKGROUPS][BANKSPERGROUP];
  logic [COLWIDTH-1:0]       bank_col_q [BANKGROUPS][BANKSPERGROUP];
  logic [COLWIDTH-1:0]       bank_col_d [BANKGROUPS][BANKSPERGROUP];
  logic                      beat_valid_q, beat_valid_d;
  logic [BLW-1:0]            beat_idx_q, beat_idx_d;
  logic                      burst_done_q, burst_done_d;

  logic                      cmd_bc4_in;
  logic                      last_beat;
  logic                      accept;

`ifdef BURST_CHOP_EN
  assign cmd_bc4_in = cmd_bc4;
`else
  assign cmd_bc4_in = 1'b0;
`endif

  // Index of the final beat: 3 for a chopped burst, BL-1 otherwise.
  function automatic logic [BLW-1:0] last_index(input logic bc4);
    return bc4 ? BLW'(3) : BLW'(BL - 1);
  endfunction

  // Column for beat k: upper bits kept, low bits advance and wrap inside
  // the 4- or BL-aligned block the start column belongs to.
  function automatic logic [COLWIDTH-1:0] beat_column(
    input logic [COLWIDTH-1:0] col,
    input logic [BLW-1:0]      k,
    input logic                bc4
  );
    logic [COLWIDTH-1:0] mask;
    mask = bc4 ? COLWIDTH'(3) : COLWIDTH'(BL - 1);
    return (col & ~mask) | ((col + COLWIDTH'(k)) & mask);
  endfunction

  // The ready window is purely a function of registered state, so it also
  // reads as 1 while reset holds the machine in IDLE.
  assign last_beat = (state_q == BURST) && (cnt_q == last_index(bc4_q));
  assign cmd_ready = (state_q == IDLE) || last_beat;
  assign accept    = cmd_valid && cmd_ready;

  // Next-state logic: an accept always wins and restarts the counter at 0,
  // which is what lets a command taken on the last beat follow seamlessly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    bg_d      = bg_q;
    ba_d      = ba_q;
    row_lat_d = row_lat_q;
    col_lat_d = col_lat_q;
    wdata_d   = wdata_q;
    bc4_d     = bc4_q;
    if (accept) begin
      state_d   = BURST;
      cnt_d     = '0;
      wr_d      = cmd_wr;
      bg_d      = cmd_bg;
      ba_d      = cmd_ba;
      row_lat_d = cmd_row;
      col_lat_d = cmd_col;
      wdata_d   = cmd_wdata;
      bc4_d     = cmd_bc4_in;
    end else if (state_q == BURST) begin
      if (last_beat) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output values for the beat that will be visible after this edge. They
  // are built from the next-state values so the outputs stay registered.
  always_comb begin
    for (int g = 0; g < BANKGROUPS; g++) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        bank_wr_d[g][b]  = 1'b0;
        bank_dq_d[g][b]  = '0;
        bank_row_d[g][b] = '0;
        bank_col_d[g][b] = '0;
      end
    end
    beat_valid_d = 1'b0;
    beat_idx_d   = '0;
    burst_done_d = 1'b0;
    if (state_d == BURST) begin
      beat_valid_d = 1'b1;
      beat_idx_d   = cnt_d;
      burst_done_d = (cnt_d == last_index(bc4_d));
      bank_wr_d[bg_d][ba_d]  = wr_d;
      bank_dq_d[bg_d][ba_d]  = wr_d ? wdata_d[int'(cnt_d)*DEVICE_WIDTH +: DEVICE_WIDTH]
                                    : '0;
      bank_row_d[bg_d][ba_d] = row_lat_d;
      bank_col_d[bg_d][ba_d] = beat_column(col_lat_d, cnt_d, bc4_d);
    end
  end

  // Control and command-capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      bg_q      <= '0;
      ba_q      <= '0;
      row_lat_q <= '0;
      col_lat_q <= '0;
      wdata_q   <= '0;
      bc4_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      bg_q      <= bg_d;
      ba_q      <= ba_d;
      row_lat_q <= row_lat_d;
      col_lat_q <= col_lat_d;
      wdata_q   <= wdata_d;
      bc4_q     <= bc4_d;
    end
  end

  // Output registers; reset clears every bank at once, abandoning any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          bank_wr_q[g][b]  <= 1'b0;
          bank_dq_q[g][b]  <= '0;
          bank_row_q[g][b] <= '0;
          bank_col_q[g][b] <= '0;
        end
      end
      beat_valid_q <= 1'b0;
      beat_idx_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          bank_wr_q[g][b]  <= bank_wr_d[g][b];
          bank_dq_q[g][b]  <= bank_dq_d[g][b];
          bank_row_q[g][b] <= bank_row_d[g][b];
          bank_col_q[g][b] <= bank_col_d[g][b];
        end
      end
      beat_valid_q <= beat_valid_d;
      beat_idx_q   <= beat_idx_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign rd_o_wr    = bank_wr_q;
  assign dqin       = bank_dq_q;
  assign row        = bank_row_q;
  assign column     = bank_col_q;
  assign beat_valid = beat_valid_q;
  assign beat_idx   = beat_idx_q;
  assign burst_done = burst_done_q;

endmodule
